// File: rtl/pll_lock_monitor.sv
// PLL reset/lock sequencer on refclk: drives pll_rst, qualifies the PLL locked
// output and releases the downstream system reset once lock is stable.
module pll_lock_monitor #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 1000000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       timeout,
  output logic [7:0] relock_cnt
);

  localparam int unsigned RELOCK_W = 8;

  localparam logic [CNT_W-1:0]    RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE      = CNT_W'(1);
  localparam logic [RELOCK_W-1:0] RELOCK_MAX   = RELOCK_W'(255);
  localparam logic [RELOCK_W-1:0] RELOCK_ONE   = RELOCK_W'(1);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   lock_s;

  state_e                 state_q;
  state_e                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   timeout_q;
  logic                   timeout_d;
  logic [RELOCK_W-1:0]    relock_q;
  logic [RELOCK_W-1:0]    relock_d;

  // Shift the asynchronous locked input into the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], locked};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Synchronizer flops; cleared by rst so a stale lock cannot leak past reset.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // State register together with the shared counter and the status flops.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      relock_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      relock_q  <= relock_d;
    end
  end

  // Next-state, counter and status update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    relock_d  = relock_q;

    unique case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_WAIT_LOCK: begin
        // A lock seen on the final timeout cycle still wins.
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = S_RESET_PLL;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STABLE: begin
        // Any drop during qualification restarts the wait from scratch.
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RUN: begin
        if (!lock_s) begin
          state_d  = S_RESET_PLL;
          cnt_d    = '0;
          relock_d = (relock_q == RELOCK_MAX) ? relock_q : relock_q + RELOCK_ONE;
        end
      end

      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded straight from the state register and status flops.
  always_comb begin
    pll_rst    = (state_q == S_RESET_PLL);
    sys_rst    = (state_q != S_RUN);
    ready      = (state_q == S_RUN);
    timeout    = timeout_q;
    relock_cnt = relock_q;
  end

endmodule
